// File: rtl/i2c_target_regport_pkg.sv
// i2c_target_regport shared types and constants.
// FSM state encoding, SDA drive levels, bit-counter width.
package i2c_target_regport_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RACK,
      ST_IGNORE
   } state_t;

   localparam logic SDA_ACK = 1'b0;
   localparam logic SDA_REL = 1'b1;

   localparam int BITCNT_W = 3;
   localparam logic [BITCNT_W-1:0] BIT_LAST = 3'd7;

endpackage

// File: rtl/i2c_target_regport_if.sv
// i2c_target_regport bus bundle: open-drain I2C pins and register port.
// slave = the target, master = whatever drives the pins and serves rdata.
interface i2c_target_regport_if #(
   parameter int ADDR_W = 8
);

   logic              io_i2c_scl_read;
   logic              io_i2c_sda_read;
   logic              io_i2c_sda_write;
   logic [ADDR_W-1:0] io_reg_addr;
   logic [7:0]        io_reg_wdata;
   logic              io_reg_we;
   logic [7:0]        io_reg_rdata;
   logic              io_busy;

   modport slave (
      input  io_i2c_scl_read,
      input  io_i2c_sda_read,
      input  io_reg_rdata,
      output io_i2c_sda_write,
      output io_reg_addr,
      output io_reg_wdata,
      output io_reg_we,
      output io_busy
   );

   modport master (
      output io_i2c_scl_read,
      output io_i2c_sda_read,
      output io_reg_rdata,
      input  io_i2c_sda_write,
      input  io_reg_addr,
      input  io_reg_wdata,
      input  io_reg_we,
      input  io_busy
   );

endinterface

// File: rtl/i2c_target_regport_filter.sv
// Per-line input conditioner: 2-FF sync, then FILTER_LEN stability filter.
// Ports: i_clk, i_rst_n, i_raw -> o_level, o_rise, o_fall (1-cycle pulses).
module i2c_target_regport_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    r_sync;
   logic          r_level;
   logic          r_level_d;
   logic [CW-1:0] r_cnt;

   // Idle bus is high on both lines, so everything resets to 1.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync    <= 2'b11;
         r_level   <= 1'b1;
         r_level_d <= 1'b1;
         r_cnt     <= '0;
      end else begin
         r_sync    <= {r_sync[0], i_raw};
         r_level_d <= r_level;
         // Accept a new level only after FILTER_LEN consecutive cycles.
         if (r_sync[1] == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
            r_level <= r_sync[1];
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_level & ~r_level_d;
   assign o_fall  = ~r_level & r_level_d;

endmodule

// File: rtl/i2c_target_regport.sv
// I2C target with byte-wide register port and auto-incrementing pointer.
// Ports: io_mainClk, io_asyncResetn, bus (slave: pins, reg port, busy).
module i2c_target_regport
   import i2c_target_regport_pkg::*;
#(
   parameter logic [6:0] TARGET_ADDR = 7'h42,
   parameter int         ADDR_W      = 8,
   parameter int         FILTER_LEN  = 3
) (
   input logic                  io_mainClk,
   input logic                  io_asyncResetn,
   i2c_target_regport_if.slave  bus
);

   logic [1:0]          r_rst_sync;
   logic                w_rst_n;
   logic                w_scl_lvl, w_scl_rise, w_scl_fall;
   logic                w_sda_lvl, w_sda_rise, w_sda_fall;
   logic                w_scl_edge, w_start, w_stop;
   logic [7:0]          w_byte;

   state_t              r_state, w_state_n;
   logic [7:0]          r_shreg, w_shreg_n;
   logic [BITCNT_W-1:0] r_bitcnt, w_bitcnt_n;
   logic [ADDR_W-1:0]   r_addr, w_addr_n;
   logic [7:0]          r_wdata, w_wdata_n;
   logic                r_we, w_we_n;
   logic                r_inc, w_inc_n;
   logic                r_busy, w_busy_n;
   logic                r_sda, w_sda_n;
   logic                r_acked, w_acked_n;

   // Asynchronous assertion, synchronous release.
   always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) r_rst_sync <= 2'b00;
      else                 r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   i2c_target_regport_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
      .i_clk(io_mainClk), .i_rst_n(w_rst_n), .i_raw(bus.io_i2c_scl_read),
      .o_level(w_scl_lvl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
   );

   i2c_target_regport_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
      .i_clk(io_mainClk), .i_rst_n(w_rst_n), .i_raw(bus.io_i2c_sda_read),
      .o_level(w_sda_lvl), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
   );

   // An SCL edge in the same cycle masks any SDA edge.
   assign w_scl_edge = w_scl_rise | w_scl_fall;
   assign w_start    = w_sda_fall & w_scl_lvl & ~w_scl_edge;
   assign w_stop     = w_sda_rise & w_scl_lvl & ~w_scl_edge;
   assign w_byte     = {r_shreg[6:0], w_sda_lvl};

   always_ff @(posedge io_mainClk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state  <= ST_IDLE;
         r_shreg  <= '0;
         r_bitcnt <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_we     <= 1'b0;
         r_inc    <= 1'b0;
         r_busy   <= 1'b0;
         r_sda    <= SDA_REL;
         r_acked  <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_shreg  <= w_shreg_n;
         r_bitcnt <= w_bitcnt_n;
         r_addr   <= w_addr_n;
         r_wdata  <= w_wdata_n;
         r_we     <= w_we_n;
         r_inc    <= w_inc_n;
         r_busy   <= w_busy_n;
         r_sda    <= w_sda_n;
         r_acked  <= w_acked_n;
      end
   end

   always_comb begin
      w_state_n  = r_state;
      w_shreg_n  = r_shreg;
      w_bitcnt_n = r_bitcnt;
      w_addr_n   = r_addr;
      w_wdata_n  = r_wdata;
      w_we_n     = 1'b0;
      w_inc_n    = 1'b0;
      w_busy_n   = r_busy;
      w_sda_n    = r_sda;
      w_acked_n  = r_acked;

      // Pointer bump lands the cycle after the write strobe.
      if (r_inc) w_addr_n = r_addr + ADDR_W'(1);

      if (w_stop || w_start) begin
         w_state_n  = w_stop ? ST_IDLE : ST_ADDR;
         w_sda_n    = SDA_REL;
         w_busy_n   = 1'b0;
         w_bitcnt_n = '0;
         w_acked_n  = 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE, ST_IGNORE: begin
            end
            ST_ADDR, ST_PTR, ST_WDATA: begin
               if (w_scl_rise) begin
                  w_shreg_n  = w_byte;
                  w_bitcnt_n = r_bitcnt + BITCNT_W'(1);
                  if (r_bitcnt == BIT_LAST) begin
                     if (r_state == ST_ADDR) begin
                        w_state_n = (w_byte[7:1] == TARGET_ADDR) ?
                                    ST_ADDR_ACK : ST_IGNORE;
                     end else if (r_state == ST_PTR) begin
                        w_addr_n  = ADDR_W'(w_byte);
                        w_state_n = ST_PTR_ACK;
                     end else begin
                        w_wdata_n = w_byte;
                        w_we_n    = 1'b1;
                        w_inc_n   = 1'b1;
                        w_state_n = ST_WDATA_ACK;
                     end
                  end
               end
            end
            // First fall starts the ACK, second fall ends it.
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
               if (w_scl_fall) begin
                  if (r_sda == SDA_REL) begin
                     w_sda_n = SDA_ACK;
                     if (r_state == ST_ADDR_ACK) w_busy_n = 1'b1;
                  end else if (r_state == ST_ADDR_ACK && r_shreg[0]) begin
                     w_shreg_n  = bus.io_reg_rdata;
                     w_sda_n    = bus.io_reg_rdata[7];
                     w_bitcnt_n = '0;
                     w_state_n  = ST_RDATA;
                  end else begin
                     w_sda_n    = SDA_REL;
                     w_bitcnt_n = '0;
                     w_state_n  = (r_state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                  end
               end
            end
            ST_RDATA: begin
               if (w_scl_rise) begin
                  w_bitcnt_n = r_bitcnt + BITCNT_W'(1);
                  if (r_bitcnt == BIT_LAST) w_state_n = ST_RACK;
               end else if (w_scl_fall) begin
                  w_shreg_n = {r_shreg[6:0], 1'b0};
                  w_sda_n   = r_shreg[6];
               end
            end
            ST_RACK: begin
               if (w_scl_rise) begin
                  if (w_sda_lvl == SDA_ACK) begin
                     w_addr_n  = r_addr + ADDR_W'(1);
                     w_acked_n = 1'b1;
                  end else begin
                     w_state_n = ST_IGNORE;
                     w_busy_n  = 1'b0;
                     w_sda_n   = SDA_REL;
                  end
               end else if (w_scl_fall) begin
                  if (r_acked) begin
                     w_shreg_n  = bus.io_reg_rdata;
                     w_sda_n    = bus.io_reg_rdata[7];
                     w_bitcnt_n = '0;
                     w_acked_n  = 1'b0;
                     w_state_n  = ST_RDATA;
                  end else begin
                     w_sda_n = SDA_REL;
                  end
               end
            end
            default: w_state_n = ST_IDLE;
         endcase
      end
   end

   assign bus.io_i2c_sda_write = r_sda;
   assign bus.io_reg_addr      = r_addr;
   assign bus.io_reg_wdata     = r_wdata;
   assign bus.io_reg_we        = r_we;
   assign bus.io_busy          = r_busy;

endmodule

// File: tb/tb_i2c_target_regport.sv
// Directed bench for i2c_target_regport acting as the I2C controller.
// Open-drain bus modelled as AND of controller and target drives.
module tb_i2c_target_regport;

   localparam int Q = 100;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic scl_c = 1'b1;
   logic sda_c = 1'b1;
   wire  sda_bus;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] we_log[$];
   int sda_low_cnt = 0;
   int busy_cnt    = 0;

   i2c_target_regport_if #(.ADDR_W(8)) bus ();

   assign sda_bus              = sda_c & bus.io_i2c_sda_write;
   assign bus.io_i2c_scl_read  = scl_c;
   assign bus.io_i2c_sda_read  = sda_bus;
   assign bus.io_reg_rdata     = bus.io_reg_addr ^ 8'hFF;

   i2c_target_regport #(
      .TARGET_ADDR(7'h42), .ADDR_W(8), .FILTER_LEN(3)
   ) dut (
      .io_mainClk(clk),
      .io_asyncResetn(rst_n),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.io_reg_we) we_log.push_back({bus.io_reg_addr, bus.io_reg_wdata});
      if (!bus.io_i2c_sda_write) sda_low_cnt++;
      if (bus.io_busy) busy_cnt++;
   end

   task automatic i2c_start();
      sda_c = 1'b1; #(Q);
      scl_c = 1'b1; #(Q);
      sda_c = 1'b0; #(Q);
      scl_c = 1'b0; #(Q);
   endtask

   task automatic i2c_stop();
      sda_c = 1'b0; #(Q);
      scl_c = 1'b1; #(Q);
      sda_c = 1'b1; #(Q);
   endtask

   task automatic bit_out(input logic b);
      sda_c = b; #(Q);
      scl_c = 1'b1; #(2*Q);
      scl_c = 1'b0; #(Q);
   endtask

   task automatic byte_out(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) bit_out(d[i]);
      sda_c = 1'b1; #(Q);
      scl_c = 1'b1; #(Q);
      ack = sda_bus; #(Q);
      scl_c = 1'b0; #(Q);
   endtask

   task automatic byte_in(input logic ack, output logic [7:0] d);
      for (int i = 7; i >= 0; i--) begin
         sda_c = 1'b1; #(Q);
         scl_c = 1'b1; #(Q);
         d[i] = sda_bus; #(Q);
         scl_c = 1'b0; #(Q);
      end
      bit_out(ack);
   endtask

   task automatic test_reset();
      n_checks++;
      if (bus.io_i2c_sda_write !== 1'b1) begin
         n_fail++; $display("FAIL rst_sda got=%b exp=1", bus.io_i2c_sda_write);
      end
      n_checks++;
      if (bus.io_reg_addr !== 8'h00) begin
         n_fail++; $display("FAIL rst_addr got=%h exp=00", bus.io_reg_addr);
      end
      n_checks++;
      if (bus.io_reg_wdata !== 8'h00) begin
         n_fail++; $display("FAIL rst_wdata got=%h exp=00", bus.io_reg_wdata);
      end
      n_checks++;
      if (bus.io_reg_we !== 1'b0) begin
         n_fail++; $display("FAIL rst_we got=%b exp=0", bus.io_reg_we);
      end
      n_checks++;
      if (bus.io_busy !== 1'b0) begin
         n_fail++; $display("FAIL rst_busy got=%b exp=0", bus.io_busy);
      end
   endtask

   task automatic test_write();
      logic a0, a1, a2, a3;
      int base;
      base = we_log.size();
      i2c_start();
      byte_out(8'h84, a0);
      n_checks++;
      if (bus.io_busy !== 1'b1) begin
         n_fail++; $display("FAIL wr_busy got=%b exp=1", bus.io_busy);
      end
      byte_out(8'h10, a1);
      byte_out(8'hA5, a2);
      byte_out(8'h5A, a3);
      i2c_stop(); #(Q);
      n_checks++;
      if ({a0, a1, a2, a3} !== 4'b0000) begin
         n_fail++; $display("FAIL wr_acks got=%b exp=0000", {a0, a1, a2, a3});
      end
      n_checks++;
      if (we_log.size() - base != 2) begin
         n_fail++; $display("FAIL wr_we_cnt got=%0d exp=2", we_log.size() - base);
      end else begin
         n_checks++;
         if (we_log[base] !== 16'h10A5) begin
            n_fail++; $display("FAIL wr_we0 got=%h exp=10a5", we_log[base]);
         end
         n_checks++;
         if (we_log[base+1] !== 16'h115A) begin
            n_fail++; $display("FAIL wr_we1 got=%h exp=115a", we_log[base+1]);
         end
      end
      n_checks++;
      if (bus.io_reg_addr !== 8'h12) begin
         n_fail++; $display("FAIL wr_ptr got=%h exp=12", bus.io_reg_addr);
      end
      n_checks++;
      if (bus.io_busy !== 1'b0 || bus.io_i2c_sda_write !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_stop got=busy%b sda%b exp=busy0 sda1",
                  bus.io_busy, bus.io_i2c_sda_write);
      end
   endtask

   task automatic test_read();
      logic a0, a1, a2;
      logic [7:0] d0, d1, d2;
      int base;
      base = we_log.size();
      i2c_start();
      byte_out(8'h84, a0);
      byte_out(8'h20, a1);
      i2c_start();
      byte_out(8'h85, a2);
      byte_in(1'b0, d0);
      byte_in(1'b0, d1);
      byte_in(1'b1, d2);
      n_checks++;
      if (bus.io_busy !== 1'b0) begin
         n_fail++; $display("FAIL rd_nack_busy got=%b exp=0", bus.io_busy);
      end
      i2c_stop(); #(Q);
      n_checks++;
      if ({a0, a1, a2} !== 3'b000) begin
         n_fail++; $display("FAIL rd_acks got=%b exp=000", {a0, a1, a2});
      end
      n_checks++;
      if ({d0, d1, d2} !== 24'hDFDEDD) begin
         n_fail++; $display("FAIL rd_data got=%h exp=dfdedd", {d0, d1, d2});
      end
      n_checks++;
      if (bus.io_reg_addr !== 8'h22) begin
         n_fail++; $display("FAIL rd_ptr got=%h exp=22", bus.io_reg_addr);
      end
      n_checks++;
      if (we_log.size() != base) begin
         n_fail++; $display("FAIL rd_no_we got=%0d exp=0", we_log.size() - base);
      end
   endtask

   task automatic test_mismatch();
      logic a0, a1;
      int base, low0, busy0;
      base  = we_log.size();
      low0  = sda_low_cnt;
      busy0 = busy_cnt;
      i2c_start();
      byte_out(8'h86, a0);
      byte_out(8'h55, a1);
      i2c_stop(); #(Q);
      n_checks++;
      if ({a0, a1} !== 2'b11) begin
         n_fail++; $display("FAIL mm_ack got=%b exp=11", {a0, a1});
      end
      n_checks++;
      if (sda_low_cnt != low0) begin
         n_fail++; $display("FAIL mm_sda_low got=%0d exp=0", sda_low_cnt - low0);
      end
      n_checks++;
      if (busy_cnt != busy0) begin
         n_fail++; $display("FAIL mm_busy got=%0d exp=0", busy_cnt - busy0);
      end
      n_checks++;
      if (we_log.size() != base) begin
         n_fail++; $display("FAIL mm_we got=%0d exp=0", we_log.size() - base);
      end
   endtask

   task automatic test_wrap();
      logic a0, a1, a2, a3;
      int base;
      base = we_log.size();
      i2c_start();
      byte_out(8'h84, a0);
      byte_out(8'hFF, a1);
      byte_out(8'h11, a2);
      byte_out(8'h22, a3);
      i2c_stop(); #(Q);
      n_checks++;
      if (we_log.size() - base != 2) begin
         n_fail++; $display("FAIL wrap_we_cnt got=%0d exp=2", we_log.size() - base);
      end else begin
         n_checks++;
         if ({we_log[base], we_log[base+1]} !== 32'hFF11_0022) begin
            n_fail++;
            $display("FAIL wrap_we got=%h %h exp=ff11 0022",
                     we_log[base], we_log[base+1]);
         end
      end
      n_checks++;
      if (bus.io_reg_addr !== 8'h01) begin
         n_fail++; $display("FAIL wrap_ptr got=%h exp=01", bus.io_reg_addr);
      end
   endtask

   task automatic test_abort();
      logic a0, a1, a2, a3;
      int base;
      base = we_log.size();
      i2c_start();
      byte_out(8'h84, a0);
      byte_out(8'h30, a1);
      bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
      i2c_stop(); #(Q);
      n_checks++;
      if (we_log.size() != base) begin
         n_fail++; $display("FAIL ab_we got=%0d exp=0", we_log.size() - base);
      end
      n_checks++;
      if (bus.io_i2c_sda_write !== 1'b1 || bus.io_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ab_idle got=sda%b busy%b exp=sda1 busy0",
                  bus.io_i2c_sda_write, bus.io_busy);
      end
      n_checks++;
      if (bus.io_reg_addr !== 8'h30) begin
         n_fail++; $display("FAIL ab_ptr got=%h exp=30", bus.io_reg_addr);
      end
      i2c_start();
      byte_out(8'h84, a2);
      byte_out(8'h40, a3);
      byte_out(8'h77, a0);
      i2c_stop(); #(Q);
      n_checks++;
      if (we_log.size() - base != 1) begin
         n_fail++; $display("FAIL ab_next_cnt got=%0d exp=1", we_log.size() - base);
      end else begin
         n_checks++;
         if (we_log[base] !== 16'h4077) begin
            n_fail++; $display("FAIL ab_next_we got=%h exp=4077", we_log[base]);
         end
      end
   endtask

   task automatic test_glitch();
      logic a0;
      int busy0;
      busy0 = busy_cnt;
      @(negedge clk) sda_c = 1'b0;
      @(negedge clk) sda_c = 1'b1;
      repeat (20) @(negedge clk);
      sda_c = 1'b0;
      repeat (2) @(negedge clk);
      sda_c = 1'b1;
      repeat (20) @(negedge clk);
      scl_c = 1'b0; #(Q);
      byte_out(8'h84, a0);
      i2c_stop(); #(Q);
      n_checks++;
      if (a0 !== 1'b1) begin
         n_fail++; $display("FAIL gl_no_start got=ack%b exp=ack1", a0);
      end
      n_checks++;
      if (busy_cnt != busy0) begin
         n_fail++; $display("FAIL gl_busy got=%0d exp=0", busy_cnt - busy0);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      logic a0, a1, a2;
      int base;
      d = 8'h84;
      i2c_start();
      for (int i = 7; i >= 0; i--) bit_out(d[i]);
      sda_c = 1'b1; #(Q);
      n_checks++;
      if (bus.io_i2c_sda_write !== 1'b0 || bus.io_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rm_ack_drv got=sda%b busy%b exp=sda0 busy1",
                  bus.io_i2c_sda_write, bus.io_busy);
      end
      rst_n = 1'b0; #1;
      n_checks++;
      if (bus.io_i2c_sda_write !== 1'b1 || bus.io_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rm_release got=sda%b busy%b exp=sda1 busy0",
                  bus.io_i2c_sda_write, bus.io_busy);
      end
      #(Q-1);
      rst_n = 1'b1; #(Q);
      scl_c = 1'b1; #(2*Q);
      scl_c = 1'b0; #(Q);
      i2c_stop(); #(Q);
      base = we_log.size();
      i2c_start();
      byte_out(8'h84, a0);
      byte_out(8'h05, a1);
      byte_out(8'h99, a2);
      i2c_stop(); #(Q);
      n_checks++;
      if (we_log.size() - base != 1) begin
         n_fail++; $display("FAIL rm_next_cnt got=%0d exp=1", we_log.size() - base);
      end else begin
         n_checks++;
         if (we_log[base] !== 16'h0599) begin
            n_fail++; $display("FAIL rm_next_we got=%h exp=0599", we_log[base]);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      #(Q);
      rst_n = 1'b1;
      #(Q);
      test_reset();
      test_write();
      test_read();
      test_mismatch();
      test_wrap();
      test_abort();
      test_glitch();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
